// File: rtl/vram_arbiter_if.sv
// vram_arbiter bus bundle: video fetch port, CPU port and memory port.
// slave = arbiter side, master = requesters/memory side.
interface vram_arbiter_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
);
  logic                  vid_req;
  logic [ADDR_WIDTH-1:0] vid_addr;
  logic                  vid_ack;
  logic [DATA_WIDTH-1:0] vid_data;
  logic                  vid_valid;

  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_ack;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_rvalid;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  vid_req, vid_addr,
    output vid_ack, vid_data, vid_valid,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_rvalid,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output vid_req, vid_addr,
    input  vid_ack, vid_data, vid_valid,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_rvalid,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// VRAM arbiter: video fixed priority, CPU guaranteed a slot by a starvation limiter.
// Optional ARB_STATS_EN adds the cpu_stall_cnt output.
module vram_arbiter #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic         clk,
  input  logic         reset,
  vram_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]  cpu_stall_cnt
`endif
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt;
  logic       force_cpu;
  logic       grant_vid;
  logic       grant_cpu;
  logic       cpu_rd;
  logic       tag_vld;
  logic       tag_cpu;

  always_comb begin
    force_cpu = (starve_cnt == LIMIT);
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    if (!reset) begin
      if (bus.vid_req && !(bus.cpu_req && force_cpu))
        grant_vid = 1'b1;
      else if (bus.cpu_req)
        grant_cpu = 1'b1;
    end
    cpu_rd = grant_cpu && !bus.cpu_we;
  end

  assign bus.vid_ack = grant_vid;
  assign bus.cpu_ack = grant_cpu;

  // Only video grants with a waiting CPU count toward starvation.
  always_ff @(posedge clk) begin
    if (reset)
      starve_cnt <= '0;
    else if (grant_vid && bus.cpu_req)
      starve_cnt <= starve_cnt + 8'd1;
    else
      starve_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= grant_cpu && bus.cpu_we;
      if (grant_vid)
        bus.mem_addr <= bus.vid_addr;
      else if (grant_cpu)
        bus.mem_addr <= bus.cpu_addr;
      if (grant_cpu && bus.cpu_we)
        bus.mem_wdata <= bus.cpu_wdata;
    end
  end

  // Tag follows the read into the RAM; return stage routes by owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld        <= 1'b0;
      tag_cpu        <= 1'b0;
      bus.vid_valid  <= 1'b0;
      bus.cpu_rvalid <= 1'b0;
      bus.vid_data   <= '0;
      bus.cpu_rdata  <= '0;
    end else begin
      tag_vld        <= grant_vid || cpu_rd;
      tag_cpu        <= grant_cpu;
      bus.vid_valid  <= tag_vld && !tag_cpu;
      bus.cpu_rvalid <= tag_vld && tag_cpu;
      if (tag_vld && !tag_cpu)
        bus.vid_data <= bus.mem_rdata;
      if (tag_vld && tag_cpu)
        bus.cpu_rdata <= bus.mem_rdata;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)
      cpu_stall_cnt <= '0;
    else if (bus.cpu_req && !grant_cpu && cpu_stall_cnt != 16'hFFFF)
      cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter against a grant-order reference model.
// Memory stub: registered address from the arbiter, combinational read.
module tb_vram_arbiter;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int LIM = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef ARB_STATS_EN
  logic [15:0] cpu_stall_cnt;
`endif

  vram_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef ARB_STATS_EN
    ,
    .cpu_stall_cnt(cpu_stall_cnt)
`endif
  );

  logic [DW-1:0] mem [2048];
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 8'(i);
      mem_ready <= 1'b1;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int            due;
    bit            cpu;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           pend[$];
  logic [DW-1:0] ref_mem [2048];
  int            cyc = 0;
  int            starve = 0;
  bit            armed = 1'b0;
  bit            lgv, lgc;
  logic [AW-1:0] e_maddr = '0;
  logic          e_mwe = 1'b0;
  logic [DW-1:0] e_mwdata = '0;
  logic          e_vvalid = 1'b0, e_cvalid = 1'b0;
  logic [DW-1:0] e_vdata = '0, e_cdata = '0;
  int            e_stall = 0;

  task automatic cycle();
    bit gv, gc;
    @(negedge clk);
    gv = 1'b0;
    gc = 1'b0;
    if (!reset) begin
      if (bus.vid_req && bus.cpu_req) begin
        gc = (starve == LIM);
        gv = !gc;
      end else begin
        gv = bus.vid_req;
        gc = bus.cpu_req;
      end
    end
    chk("vid_ack", 32'(bus.vid_ack), 32'(gv));
    chk("cpu_ack", 32'(bus.cpu_ack), 32'(gc));
    if (armed) begin
      chk("mem_addr", 32'(bus.mem_addr), 32'(e_maddr));
      chk("mem_we", 32'(bus.mem_we), 32'(e_mwe));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_mwdata));
      chk("vid_valid", 32'(bus.vid_valid), 32'(e_vvalid));
      chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(e_cvalid));
      chk("vid_data", 32'(bus.vid_data), 32'(e_vdata));
      chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(e_cdata));
`ifdef ARB_STATS_EN
      chk("cpu_stall_cnt", 32'(cpu_stall_cnt), 32'(e_stall));
`endif
    end
    if (reset) begin
      pend.delete();
      starve = 0;
      e_maddr = '0; e_mwe = 1'b0; e_mwdata = '0;
      e_vvalid = 1'b0; e_cvalid = 1'b0;
      e_vdata = '0; e_cdata = '0;
      e_stall = 0;
    end else begin
      e_mwe = gc && bus.cpu_we;
      if (gv) begin
        e_maddr = bus.vid_addr;
        pend.push_back('{cyc + 2, 1'b0, ref_mem[bus.vid_addr]});
      end
      if (gc) begin
        e_maddr = bus.cpu_addr;
        if (bus.cpu_we) begin
          e_mwdata = bus.cpu_wdata;
          ref_mem[bus.cpu_addr] = bus.cpu_wdata;
        end else begin
          pend.push_back('{cyc + 2, 1'b1, ref_mem[bus.cpu_addr]});
        end
      end
      starve = (gv && bus.cpu_req) ? starve + 1 : 0;
      if (bus.cpu_req && !gc && e_stall < 65535) e_stall++;
      e_vvalid = 1'b0;
      e_cvalid = 1'b0;
      while (pend.size() > 0 && pend[0].due == cyc + 1) begin
        if (pend[0].cpu) begin
          e_cvalid = 1'b1;
          e_cdata = pend[0].data;
        end else begin
          e_vvalid = 1'b1;
          e_vdata = pend[0].data;
        end
        void'(pend.pop_front());
      end
    end
    lgv = gv;
    lgc = gc;
    cyc++;
    @(posedge clk);
    #1;
    armed = 1'b1;
  endtask

  task automatic idle(input int n);
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'(i);
    bus.vid_req = 1'b0; bus.vid_addr = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    idle(2);

    bus.vid_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.vid_addr = 11'(i);
      cycle();
    end
    idle(3);

    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
    bus.cpu_addr = 11'h123; bus.cpu_wdata = 8'hA5;
    cycle();
    bus.cpu_we = 1'b0;
    cycle();
    idle(3);

    bus.vid_req = 1'b1; bus.vid_addr = 11'h000;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 11'h040;
    for (int i = 0; i < 27; i++) begin
      cycle();
      if (lgv) bus.vid_addr = bus.vid_addr + 11'd1;
      if (lgc) bus.cpu_addr = bus.cpu_addr + 11'd1;
    end
    idle(3);

    bus.vid_req = 1'b1; bus.vid_addr = 11'h010;
    cycle();
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 11'h020;
    cycle();
    idle(3);

    bus.vid_req = 1'b1; bus.vid_addr = 11'h030;
    cycle();
    bus.vid_req = 1'b0;
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    bus.vid_req = 1'b1; bus.vid_addr = 11'h005;
    cycle();
    idle(4);

    for (int n = 0; n < 3000; n++) begin
      if (!bus.vid_req || lgv) begin
        bus.vid_req = ($urandom_range(0, 3) != 0);
        bus.vid_addr = 11'($urandom_range(0, 31));
      end
      if (!bus.cpu_req || lgc) begin
        bus.cpu_req = ($urandom_range(0, 1) != 0);
        bus.cpu_we = ($urandom_range(0, 2) == 0);
        bus.cpu_addr = 11'($urandom_range(0, 31));
        bus.cpu_wdata = 8'($urandom);
      end
      cycle();
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
